// File: rtl/byte_striping.sv
// Byte striper: deals a serial symbol stream round-robin across LANES lanes and
// presents each completed (or flush-padded) lane word with a one-cycle strobe.
module byte_striping #(
    parameter int         LANES    = 4,
    parameter logic [7:0] IDLE_SYM = 8'h00,
    parameter int         PTR_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enb,
    input  logic [7:0]           tx_in,
    input  logic                 tx_valid_in,
    input  logic                 flush,
    output logic [8*LANES-1:0]   lane_data,
    output logic [LANES-1:0]     lane_ctl,
    output logic                 lane_strobe,
    output logic [PTR_W-1:0]     lane_ptr,
    output logic [7:0]           pad_count
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FILL  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     w_ptr_next;
    logic [8*LANES-1:0]   r_lane_data;
    logic [LANES-1:0]     r_lane_ctl;
    logic                 r_strobe;
    logic [7:0]           r_pad_count;

    logic                 w_last;
    logic                 w_full_emit;
    logic                 w_pad_emit;
    logic                 w_emit;
    logic [8*LANES-1:0]   w_word_data;
    logic [LANES-1:0]     w_word_ctl;

    // A full word takes priority over flush: if the incoming byte completes the
    // word it is a normal emit and does not count as padded.
    always_comb begin
        w_last       = (r_ptr == PTR_W'(LANES - 1));
        w_full_emit  = enb && w_last;
        w_pad_emit   = flush && !w_full_emit && (enb || (r_state == S_FILL));
        w_emit       = w_full_emit || w_pad_emit;
        w_ptr_next   = r_ptr;
        if (w_emit) begin
            w_ptr_next = '0;
        end else if (enb) begin
            w_ptr_next = r_ptr + PTR_W'(1);
        end
        w_state_next = (w_ptr_next == '0) ? S_EMPTY : S_FILL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Per-lane staging slot and word assembly: lanes below the pointer come from
    // staging, the pointer lane takes the live byte, lanes above it are padded.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] r_slot_data;
            logic       r_slot_ctl;
            logic       w_below;
            logic       w_here;

            assign w_below = (PTR_W'(gi) < r_ptr);
            assign w_here  = (PTR_W'(gi) == r_ptr) && enb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_slot_data <= 8'h00;
                    r_slot_ctl  <= 1'b0;
                end else if (w_here && !w_emit) begin
                    r_slot_data <= tx_in;
                    r_slot_ctl  <= ~tx_valid_in;
                end
            end

            assign w_word_data[8*gi +: 8] = w_below ? r_slot_data :
                                            w_here  ? tx_in       : IDLE_SYM;
            assign w_word_ctl[gi]         = w_below ? r_slot_ctl  :
                                            w_here  ? ~tx_valid_in : 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_data <= '0;
            r_lane_ctl  <= '0;
            r_strobe    <= 1'b0;
            r_pad_count <= 8'h00;
        end else begin
            r_strobe <= w_emit;
            if (w_emit) begin
                r_lane_data <= w_word_data;
                r_lane_ctl  <= w_word_ctl;
            end
            if (w_pad_emit && (r_pad_count != 8'hFF)) begin
                r_pad_count <= r_pad_count + 8'h01;
            end
        end
    end

    assign lane_data   = r_lane_data;
    assign lane_ctl    = r_lane_ctl;
    assign lane_strobe = r_strobe;
    assign lane_ptr    = r_ptr;
    assign pad_count   = r_pad_count;

endmodule

// File: tb/tb_byte_striping.sv
// Scoreboard bench for byte_striping (LANES=4): stimulus pushes expected words
// with their due cycle, a negedge monitor pops and compares on every strobe.
module tb_byte_striping;

    localparam int LANES = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enb;
    logic [7:0]           tx_in;
    logic                 tx_valid_in;
    logic                 flush;
    logic [8*LANES-1:0]   lane_data;
    logic [LANES-1:0]     lane_ctl;
    logic                 lane_strobe;
    logic [1:0]           lane_ptr;
    logic [7:0]           pad_count;

    byte_striping #(
        .LANES    (LANES),
        .IDLE_SYM (8'h00),
        .PTR_W    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .tx_in       (tx_in),
        .tx_valid_in (tx_valid_in),
        .flush       (flush),
        .lane_data   (lane_data),
        .lane_ctl    (lane_ctl),
        .lane_strobe (lane_strobe),
        .lane_ptr    (lane_ptr),
        .pad_count   (pad_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  c;
        int          cy;
    } exp_t;
    exp_t q[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Monitor: every strobe must match the oldest expected word, in its due cycle.
    always @(negedge clk) begin
        if (lane_strobe !== 1'b0) begin
            n_total++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_strobe: cycle %0d data %h ctl %b, no word expected",
                         cyc, lane_data, lane_ctl);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (lane_data === e.d && lane_ctl === e.c && cyc == e.cy) begin
                    n_pass++;
                    $display("word cycle %0d data %h ctl %b", cyc, lane_data, lane_ctl);
                end else begin
                    $display("FAIL word: got data %h ctl %b cycle %0d, required data %h ctl %b cycle %0d",
                             lane_data, lane_ctl, cyc, e.d, e.c, e.cy);
                end
            end
        end
    end

    task automatic expect_word(input logic [31:0] d, input logic [3:0] c);
        exp_t e;
        e.d  = d;
        e.c  = c;
        e.cy = cyc + 1;
        q.push_back(e);
    endtask

    // One clock of stimulus; inputs return to idle afterwards.
    task automatic step(input logic en, input logic [7:0] b, input logic v, input logic fl);
        enb         = en;
        tx_in       = b;
        tx_valid_in = v;
        flush       = fl;
        @(posedge clk);
        #1;
        enb   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic check_reset_state();
        chk("rst_lane_data", lane_data, 32'h0);
        chk("rst_lane_ctl", {28'h0, lane_ctl}, 32'h0);
        chk("rst_strobe", {31'h0, lane_strobe}, 32'h0);
        chk("rst_lane_ptr", {30'h0, lane_ptr}, 32'h0);
        chk("rst_pad_count", {24'h0, pad_count}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enb = 1'b0; tx_in = 8'h00; tx_valid_in = 1'b1; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;

        // Plain word followed back-to-back by a word with control symbols.
        step(1, 8'h11, 1, 0); step(1, 8'h22, 1, 0); step(1, 8'h33, 1, 0);
        expect_word(32'h44332211, 4'b0000);
        step(1, 8'h44, 1, 0);
        chk("ptr_after_word", {30'h0, lane_ptr}, 32'd0);
        step(1, 8'hBC, 0, 0); step(1, 8'h11, 1, 0); step(1, 8'h22, 1, 0);
        expect_word(32'hF72211BC, 4'b1001);
        step(1, 8'hF7, 0, 0);

        // Gap in the middle of a word.
        step(1, 8'h11, 1, 0);
        repeat (3) step(0, 8'hEE, 1, 0);
        chk("ptr_hold_gap", {30'h0, lane_ptr}, 32'd1);
        step(1, 8'h22, 1, 0); step(1, 8'h33, 1, 0);
        expect_word(32'h44332211, 4'b0000);
        step(1, 8'h44, 1, 0);

        // Flush of a partial word, then flush from empty.
        step(1, 8'h11, 1, 0); step(1, 8'h22, 1, 0);
        chk("ptr_partial", {30'h0, lane_ptr}, 32'd2);
        expect_word(32'h00002211, 4'b0000);
        step(0, 8'h00, 1, 1);
        chk("ptr_after_flush", {30'h0, lane_ptr}, 32'd0);
        chk("pad_after_flush", {24'h0, pad_count}, 32'd1);
        step(0, 8'h00, 1, 1);
        chk("pad_empty_flush", {24'h0, pad_count}, 32'd1);

        // Flush coinciding with the completing byte, then flush with one byte.
        step(1, 8'h11, 1, 0); step(1, 8'h22, 1, 0); step(1, 8'h33, 1, 0);
        expect_word(32'h44332211, 4'b0000);
        step(1, 8'h44, 1, 1);
        chk("pad_full_flush", {24'h0, pad_count}, 32'd1);
        expect_word(32'h00000011, 4'b0000);
        step(1, 8'h11, 1, 1);
        chk("pad_single_flush", {24'h0, pad_count}, 32'd2);
        chk("ptr_single_flush", {30'h0, lane_ptr}, 32'd0);

        // Reset discards a partial word.
        step(1, 8'h11, 1, 0); step(1, 8'h22, 1, 0);
        rst = 1'b1;
        step(0, 8'h00, 1, 0);
        check_reset_state();
        rst = 1'b0;
        step(1, 8'h55, 1, 0); step(1, 8'h66, 1, 0); step(1, 8'h77, 1, 0);
        expect_word(32'h88776655, 4'b0000);
        step(1, 8'h88, 1, 0);

        // Padded control byte keeps its ctl bit; pad lanes carry ctl=0.
        expect_word(32'h000000BC, 4'b0001);
        step(1, 8'hBC, 0, 1);
        chk("pad_ctl_flush", {24'h0, pad_count}, 32'd1);

        // Saturation of the pad counter.
        for (int i = 0; i < 260; i++) begin
            expect_word(32'h00000011, 4'b0000);
            step(1, 8'h11, 1, 1);
        end
        chk("pad_saturated", {24'h0, pad_count}, 32'hFF);

        repeat (3) step(0, 8'h00, 1, 0);
        chk("words_outstanding", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/byte_striping.md
Name: byte_striping

Overview:
- Sits directly downstream of the TX symbol multiplexer.
- Consumes its serial byte stream (8-bit symbol plus data/control flag) and distributes consecutive bytes round-robin across LANES physical lanes.
- Presents one full lane word (one byte per lane) in parallel with a one-cycle strobe.
- Supports an explicit flush that pads a partial word with the idle symbol, so a word never stalls at end of transmission.

Parameters:
- LANES, 4: number of lanes; legal values 2, 4, 8.
- IDLE_SYM, 8'h00: pad byte written into unfilled lanes on flush; matches the mux's inactive/idle value.
- PTR_W, 2: lane pointer width, equal to log2(LANES); set by the instantiator.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, synchronous, active-high.
- enb, input, 1: byte accept enable; when 1, tx_in is captured this cycle.
- tx_in, input, 8: symbol from the mux (its multiplexed output).
- tx_valid_in, input, 1: mux flag; 1 = data/idle byte, 0 = control symbol.
- flush, input, 1: close the current partial word, padding with IDLE_SYM.
- lane_data, output, 8*LANES: striped word; lane i occupies bits [8i+7:8i].
- lane_ctl, output, LANES: per-lane control flag; bit i = ~tx_valid_in of the byte in lane i.
- lane_strobe, output, 1: one-cycle pulse, 1 when lane_data/lane_ctl hold a new word.
- lane_ptr, output, PTR_W: next lane slot to fill (status).
- pad_count, output, 8: saturating count of flushed (padded) words since reset.

Behaviour:
- Reset (rst=1 at a rising edge):
  - lane_data=0, lane_ctl=0, lane_strobe=0, lane_ptr=0, pad_count=0.
  - Internal staging buffer cleared.
  - rst overrides enb and flush; a partial word in progress is discarded with no strobe.
- Staging buffer: LANES x (8-bit byte + ctl bit), written at index lane_ptr.
- Accept (enb=1, flush=0):
  - slot[lane_ptr] <= {~tx_valid_in, tx_in}.
  - If lane_ptr < LANES-1: lane_ptr increments and lane_strobe=0.
  - If lane_ptr == LANES-1: at the same edge, lane_data/lane_ctl load all staged slots plus the current byte in slot LANES-1. lane_strobe=1 for exactly one cycle and lane_ptr wraps to 0.
- Latency: the last byte of a word is visible on lane_data one clock after its accepting edge. Byte 0 of the stream always lands in lane 0.
- Idle (enb=0, flush=0): no capture, lane_ptr holds, lane_strobe=0, outputs hold the last word.
- Outputs hold between strobes; consumers sample only on lane_strobe.
- Flush, two-state FSM: FILL (lane_ptr != 0) and EMPTY (lane_ptr == 0).
  - flush=1, enb=0, FILL: emit the word with slots lane_ptr..LANES-1 = IDLE_SYM and ctl=0. lane_strobe=1, lane_ptr <= 0, pad_count++.
  - flush=1, enb=1: the current byte is first written at lane_ptr.
    - If that completes the word: normal emit, pad_count unchanged.
    - Otherwise: the remaining slots are padded, emitted in the same cycle, and pad_count++.
  - flush=1, enb=0, EMPTY: no action, no strobe.
- pad_count saturates at 8'hFF.
- Back-to-back words: enb held high gives a strobe every LANES cycles, with no bubble at wrap.
- enb is assumed 1 for every byte the mux presents; there is no backpressure output.

Test Plan (LANES=4):
- Reset, then enb=1 with bytes 11,22,33,44 (tx_valid_in=1) → one clock after the 4th edge: lane_data=32'h44332211, lane_ctl=4'b0000, lane_strobe high 1 cycle, lane_ptr=0.
- Bytes BC(valid=0),11,22,F7(valid=0) → lane_data=32'hF72211BC, lane_ctl=4'b1001.
- 11, gap (enb=0 for 3 cycles), 22, 33, 44 → no strobe during the gap; single strobe with 32'h44332211 after 44.
- 11, 22, then flush=1 with enb=0 → lane_data=32'h00002211, lane_ctl=0, strobe, lane_ptr=0, pad_count=1. A further flush with lane_ptr=0 gives no strobe and no count change.
- 11, 22, 33, then 44 with flush=1 → lane_data=32'h44332211, pad_count unchanged. 11 with flush=1 from empty → 32'h00000011, pad_count++.
- 11, 22, then rst=1 for one cycle, then 55,66,77,88 → no strobe for the discarded partial word; after reset all outputs are 0; next word is 32'h88776655.
